// File: rtl/comm_ctrl_if.sv
// Host-link bus bundle for comm_ctrl: UART byte streams, RAM override port, CPU run control.
interface comm_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              mem_override;
    logic              mem_rnw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              start;
    logic              running;

    // Controller side
    modport master (
        input  rx_valid, rx_data, tx_ready, mem_rdata, running,
        output tx_valid, tx_data, mem_override, mem_rnw, mem_addr, mem_wdata, start
    );

    // UART / RAM / CPU side
    modport slave (
        output rx_valid, rx_data, tx_ready, mem_rdata, running,
        input  tx_valid, tx_data, mem_override, mem_rnw, mem_addr, mem_wdata, start
    );
endinterface

// File: rtl/comm_ctrl.sv
// UART command controller: decodes host bytes, runs checksummed RAM block
// reads/writes through the override port, and starts the CPU.
module comm_ctrl #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MEM_DEPTH   = 32,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    comm_ctrl_if.master bus
);
    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {
        IDLE, HDR_ADDR, HDR_CNT, WR_DATA, WR_SUM,
        RD_ISSUE, RD_WAIT, RD_BYTE, RD_SUM, RD_END, REPLY
    } stateT;

    stateT             state, stateNext;
    logic              rxArmed;
    logic              isWrite, isWriteNext;
    logic [ADDR_W-1:0] baseAddr, baseAddrNext;
    logic [8:0]        wordCnt, wordCntNext;
    logic [8:0]        wordIdx, wordIdxNext;
    logic [BIDX_W-1:0] byteIdx, byteIdxNext;
    logic [7:0]        sum, sumNext;
    logic [DATA_W-1:0] word, wordNext;
    logic [7:0]        pendByte, pendByteNext;
    logic [TMR_W-1:0]  timer, timerNext;
    logic              txValid, txValidNext;
    logic [7:0]        txData, txDataNext;
    logic              memOverride, memOverrideNext;
    logic              memRnw, memRnwNext;
    logic [ADDR_W-1:0] memAddr, memAddrNext;
    logic [DATA_W-1:0] memWdata, memWdataNext;
    logic              startPulse, startNext;

    logic              rxFire, txDone, txFree;
    logic [8:0]        cntVal, wordIdxInc;
    logic [9:0]        rangeEnd;
    logic [ADDR_W-1:0] curAddr, incAddr;
    logic              lastByte, finish, timerActive;
    logic [7:0]        replyByte;
    logic [DATA_W-1:0] shiftIn;

    // The byte landing on the reset-release edge is ignored via rxArmed
    assign rxFire = bus.rx_valid && rxArmed;
    assign txDone = txValid && bus.tx_ready;
    assign txFree = !txValid || bus.tx_ready;

    assign bus.tx_valid     = txValid;
    assign bus.tx_data      = txData;
    assign bus.mem_override = memOverride;
    assign bus.mem_rnw      = memRnw;
    assign bus.mem_addr     = memAddr;
    assign bus.mem_wdata    = memWdata;
    assign bus.start        = startPulse;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // Next-state, datapath and output decode
    always_comb begin
        stateNext       = state;
        isWriteNext     = isWrite;
        baseAddrNext    = baseAddr;
        wordCntNext     = wordCnt;
        wordIdxNext     = wordIdx;
        byteIdxNext     = byteIdx;
        sumNext         = sum;
        wordNext        = word;
        pendByteNext    = pendByte;
        timerNext       = '0;
        txValidNext     = txDone ? 1'b0 : txValid;
        txDataNext      = txData;
        memOverrideNext = memOverride;
        memRnwNext      = 1'b1;
        memAddrNext     = memAddr;
        memWdataNext    = memWdata;
        startNext       = 1'b0;
        finish          = 1'b0;
        replyByte       = 8'h00;
        cntVal          = (bus.rx_data == 8'h00) ? 9'(MEM_DEPTH) : 9'(bus.rx_data);
        rangeEnd        = 10'(baseAddr) + 10'(cntVal);
        wordIdxInc      = wordIdx + 9'd1;
        curAddr         = ADDR_W'(10'(baseAddr) + 10'(wordIdx));
        incAddr         = ADDR_W'(10'(baseAddr) + 10'(wordIdxInc));
        lastByte        = (byteIdx == BIDX_W'(BYTES - 1));
        shiftIn         = (word >> 8) | (DATA_W'(bus.rx_data) << (DATA_W - 8));
        timerActive     = state inside {HDR_ADDR, HDR_CNT, WR_DATA, WR_SUM};

        case (state)
            IDLE: begin
                if (rxFire && txFree) begin
                    txValidNext = 1'b1;
                    case (bus.rx_data)
                        "p": txDataNext = "P";
                        "s": txDataNext = bus.running ? "+" : "-";
                        "x": begin
                            if (bus.running) begin
                                txDataNext = "!";
                            end else begin
                                txDataNext = "X";
                                startNext  = 1'b1;
                            end
                        end
                        "r", "w": begin
                            txValidNext = txDone ? 1'b0 : txValid;
                            isWriteNext = (bus.rx_data == "w");
                            sumNext     = 8'h00;
                            stateNext   = HDR_ADDR;
                        end
                        default: txDataNext = "?";
                    endcase
                end
            end
            HDR_ADDR: begin
                if (rxFire) begin
                    baseAddrNext = bus.rx_data[ADDR_W-1:0];
                    sumNext      = sum ^ bus.rx_data;
                    stateNext    = HDR_CNT;
                end
            end
            HDR_CNT: begin
                if (rxFire) begin
                    sumNext = sum ^ bus.rx_data;
                    if (rangeEnd > 10'(MEM_DEPTH)) begin
                        finish    = 1'b1;
                        replyByte = "!";
                    end else begin
                        wordCntNext     = cntVal;
                        wordIdxNext     = 9'd0;
                        byteIdxNext     = '0;
                        memOverrideNext = 1'b1;
                        txValidNext     = 1'b1;
                        txDataNext      = isWrite ? "W" : "R";
                        if (isWrite) begin
                            stateNext = WR_DATA;
                        end else begin
                            memAddrNext = baseAddr;
                            stateNext   = RD_ISSUE;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (rxFire) begin
                    sumNext  = sum ^ bus.rx_data;
                    wordNext = shiftIn;
                    if (lastByte) begin
                        byteIdxNext  = '0;
                        memAddrNext  = curAddr;
                        memWdataNext = shiftIn;
                        memRnwNext   = 1'b0;
                        wordIdxNext  = wordIdxInc;
                        if (wordIdxInc == wordCnt) stateNext = WR_SUM;
                    end else begin
                        byteIdxNext = byteIdx + BIDX_W'(1);
                    end
                end
            end
            WR_SUM: begin
                if (rxFire) begin
                    finish    = 1'b1;
                    replyByte = (bus.rx_data == sum) ? "E" : "C";
                end
            end
            RD_ISSUE: stateNext = RD_WAIT;
            RD_WAIT: begin
                wordNext  = bus.mem_rdata;
                stateNext = RD_BYTE;
            end
            RD_BYTE: begin
                if (txFree) begin
                    txValidNext = 1'b1;
                    txDataNext  = word[7:0];
                    sumNext     = sum ^ word[7:0];
                    wordNext    = word >> 8;
                    if (lastByte) begin
                        byteIdxNext = '0;
                        wordIdxNext = wordIdxInc;
                        if (wordIdxInc == wordCnt) begin
                            stateNext = RD_SUM;
                        end else begin
                            memAddrNext = incAddr;
                            stateNext   = RD_ISSUE;
                        end
                    end else begin
                        byteIdxNext = byteIdx + BIDX_W'(1);
                    end
                end
            end
            RD_SUM: begin
                if (txFree) begin
                    txValidNext = 1'b1;
                    txDataNext  = sum;
                    stateNext   = RD_END;
                end
            end
            RD_END: begin
                if (txFree) begin
                    txValidNext     = 1'b1;
                    txDataNext      = "E";
                    memOverrideNext = 1'b0;
                    stateNext       = IDLE;
                end
            end
            REPLY: begin
                if (txFree) begin
                    txValidNext = 1'b1;
                    txDataNext  = pendByte;
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        // Idle-RX watchdog on the host-driven phases
        if (timerActive && !rxFire) begin
            if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                finish    = 1'b1;
                replyByte = "T";
            end else begin
                timerNext = timer + TMR_W'(1);
            end
        end

        // Command end: release RAM, reply now or park the reply until TX frees up
        if (finish) begin
            memOverrideNext = 1'b0;
            if (txFree) begin
                txValidNext = 1'b1;
                txDataNext  = replyByte;
                stateNext   = IDLE;
            end else begin
                pendByteNext = replyByte;
                stateNext    = REPLY;
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxArmed     <= 1'b0;
            isWrite     <= 1'b0;
            baseAddr    <= '0;
            wordCnt     <= '0;
            wordIdx     <= '0;
            byteIdx     <= '0;
            sum         <= '0;
            word        <= '0;
            pendByte    <= '0;
            timer       <= '0;
            txValid     <= 1'b0;
            txData      <= '0;
            memOverride <= 1'b0;
            memRnw      <= 1'b1;
            memAddr     <= '0;
            memWdata    <= '0;
            startPulse  <= 1'b0;
        end else begin
            rxArmed     <= 1'b1;
            isWrite     <= isWriteNext;
            baseAddr    <= baseAddrNext;
            wordCnt     <= wordCntNext;
            wordIdx     <= wordIdxNext;
            byteIdx     <= byteIdxNext;
            sum         <= sumNext;
            word        <= wordNext;
            pendByte    <= pendByteNext;
            timer       <= timerNext;
            txValid     <= txValidNext;
            txData      <= txDataNext;
            memOverride <= memOverrideNext;
            memRnw      <= memRnwNext;
            memAddr     <= memAddrNext;
            memWdata    <= memWdataNext;
            startPulse  <= startNext;
        end
    end
endmodule
